cv32e40s_txn_tracker: RTL and testbench
=======================================

# cv32e40s_txn_tracker

Outstanding-transaction tracker between a requester (LSU or prefetcher) and the MPU on the same interface. It gates request acceptance so that no more than DEPTH transactions are in flight. It stores a per-transaction tag in a FIFO and returns that tag alongside each response. It also generates the one-pending-next-cycle indication that the MPU error FSM uses to decide when to answer a faulting access.

## Interface

Parameters:
- DEPTH, 2, maximum outstanding transactions; legal range 1..8.
- TAG_W, 2, width of the per-transaction tag (e.g. {misaligned, we}).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  requester has a transaction.
- req_ready_o  out  1  transaction accepted this cycle when high together with req_valid_i.
- req_tag_i  in  TAG_W  tag captured on acceptance.
- trans_valid_o  out  1  request forwarded to the MPU.
- trans_ready_i  in  1  MPU ready.
- resp_valid_i  in  1  response from the MPU (bus response or MPU-generated error response).
- resp_valid_o  out  1  response forwarded to the requester.
- resp_tag_o  out  TAG_W  tag of the oldest outstanding transaction.
- cnt_o  out  $clog2(DEPTH+1)  registered outstanding count.
- empty_o  out  1  cnt_o == 0.
- one_txn_pend_n_o  out  1  exactly one transaction will be outstanding next cycle.
- unexp_resp_o  out  1  sticky; a response arrived with nothing outstanding.

## Operation

- full = (cnt_q == DEPTH).
- trans_valid_o = req_valid_i && !full.
- req_ready_o = trans_ready_i && !full.
- accept = req_valid_i && req_ready_o.
- retire = resp_valid_i && (cnt_q != 0).
- If resp_valid_i is high while cnt_q == 0:
  - the response is dropped, so resp_valid_o = 0;
  - unexp_resp_o sets next cycle and holds until reset;
  - the counter and FIFO are unchanged.
- Counter: cnt_n = cnt_q + accept - retire. Under the full-gating rules the counter never exceeds DEPTH and never underflows.
- Tag FIFO, DEPTH entries:
  - write pointer and read pointer, each wrapping at DEPTH (not power-of-two; wrap explicitly DEPTH-1 -> 0);
  - push req_tag_i on accept;
  - pop on retire;
  - push and pop in the same cycle are both performed.
- resp_valid_o = retire. resp_tag_o = entry at the read pointer, driven combinationally from storage. The value is don't-care when empty, but it drives 0 in that case.
- one_txn_pend_n_o = (cnt_n == 1), combinational. This covers all cases, e.g. cnt_q=2 with a retire, cnt_q=0 with an accept, cnt_q=1 with both accept and retire.
- Transactions are strictly in order; the tag order matches the response order.

## Timing

- Reset values:
  - cnt_o = 0, empty_o = 1, unexp_resp_o = 0;
  - FIFO pointers = 0, storage = 0;
  - resp_valid_o = 0 and resp_tag_o = 0 whenever resp_valid_i = 0.
- Reset asserted mid-operation clears all state immediately. Responses still outstanding at that point count as unexpected only after reset releases.
- Zero-cycle request path: req_valid_i -> trans_valid_o and trans_ready_i -> req_ready_o are combinational.
- Zero-cycle response path: resp_valid_i -> resp_valid_o is combinational.
- The count updates on the edge after accept or retire. The earliest legal response arrives one cycle after acceptance.
- When full, req_ready_o = 0 and trans_valid_o = 0 regardless of trans_ready_i. The default build has no same-cycle refill, so a response at full frees a slot in the next cycle.

## Configuration

- CV32E40S_TXN_TRACKER_FULL_BYPASS_EN:
  - Defined: full_eff = full && !resp_valid_i. A response arriving at full allows a new accept in the same cycle, with FIFO push and pop together and cnt staying at DEPTH. This introduces a combinational path resp_valid_i -> req_ready_o / trans_valid_o.
  - Undefined: full_eff = full, with no combinational path from resp_valid_i to the request side.

## Test plan

- After reset: cnt_o=0, empty_o=1, unexp_resp_o=0, req_ready_o follows trans_ready_i. Accept one tag 2'b10 -> cnt_o=1 next cycle, one_txn_pend_n_o=1 in the accept cycle. Response -> resp_valid_o=1 with resp_tag_o=2'b10, then cnt_o=0.
- DEPTH=2: accept tags 1 and 2 back-to-back -> cnt_o=2 and req_ready_o=0 with trans_ready_i=1. Responses return tags 1 then 2 in order.
- At full, response and new request in the same cycle:
  - default build: req_ready_o=0 that cycle, accepted the next cycle;
  - with the macro: accepted the same cycle, cnt_o stays at 2, tags remain in order.
- DEPTH=3: run 10 accept/retire pairs so pointers wrap 3 times -> every resp_tag_o matches the pushed sequence and cnt_o never exceeds 3.
- cnt_q=1 with accept and retire in the same cycle -> one_txn_pend_n_o=1 and cnt_o stays at 1. cnt_q=2 with a retire -> one_txn_pend_n_o=1.
- resp_valid_i while empty -> resp_valid_o=0, unexp_resp_o=1 from the next cycle and staying high. Assert rst_n mid-stream with cnt_o=2 -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/cv32e40s_txn_tracker.sv
// Outstanding-transaction tracker: gates requests at DEPTH in flight, returns per-transaction tags in order.
// Optional macro CV32E40S_TXN_TRACKER_FULL_BYPASS_EN lets a response at full free its slot in the same cycle.
module cv32e40s_txn_tracker #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [TAG_W-1:0]           req_tag_i,
  output logic                       trans_valid_o,
  input  logic                       trans_ready_i,
  input  logic                       resp_valid_i,
  output logic                       resp_valid_o,
  output logic [TAG_W-1:0]           resp_tag_o,
  output logic [$clog2(DEPTH+1)-1:0] cnt_o,
  output logic                       empty_o,
  output logic                       one_txn_pend_n_o,
  output logic                       unexp_resp_o
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [TAG_W-1:0] mem_q [DEPTH];
  logic             unexp_q;
  logic             full, full_eff, empty, accept, retire;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);

`ifdef CV32E40S_TXN_TRACKER_FULL_BYPASS_EN
  // A retiring response vacates the head slot, so the push can reuse it this cycle.
  assign full_eff = full && !resp_valid_i;
`else
  assign full_eff = full;
`endif

  assign trans_valid_o = req_valid_i && !full_eff;
  assign req_ready_o   = trans_ready_i && !full_eff;
  assign accept        = req_valid_i && req_ready_o;
  assign retire        = resp_valid_i && !empty;

  assign cnt_n = cnt_q + CNT_W'(accept) - CNT_W'(retire);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      unexp_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_n;
      if (accept) begin
        mem_q[wptr_q] <= req_tag_i;
        wptr_q        <= ptr_inc(wptr_q);
      end
      if (retire) rptr_q <= ptr_inc(rptr_q);
      if (resp_valid_i && empty) unexp_q <= 1'b1;
    end
  end

  assign resp_valid_o     = retire;
  assign resp_tag_o       = empty ? '0 : mem_q[rptr_q];
  assign cnt_o            = cnt_q;
  assign empty_o          = empty;
  assign one_txn_pend_n_o = (cnt_n == CNT_W'(1));
  assign unexp_resp_o     = unexp_q;

endmodule

// File: tb/tb_cv32e40s_txn_tracker.sv
// Directed bench for cv32e40s_txn_tracker: DEPTH=2 instance for main behaviour, DEPTH=3 instance for pointer wrap.
module tb_cv32e40s_txn_tracker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, trans_valid, trans_ready, resp_valid, resp_valid_o;
  logic [1:0] req_tag, resp_tag, cnt;
  logic       empty, one_pend, unexp;

  logic       d3_req_valid, d3_req_ready, d3_trans_valid, d3_trans_ready, d3_resp_valid, d3_resp_valid_o;
  logic [1:0] d3_req_tag, d3_resp_tag, d3_cnt;
  logic       d3_empty, d3_one_pend, d3_unexp;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cv32e40s_txn_tracker #(.DEPTH(2), .TAG_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_tag_i(req_tag),
    .trans_valid_o(trans_valid), .trans_ready_i(trans_ready),
    .resp_valid_i(resp_valid), .resp_valid_o(resp_valid_o), .resp_tag_o(resp_tag),
    .cnt_o(cnt), .empty_o(empty), .one_txn_pend_n_o(one_pend), .unexp_resp_o(unexp)
  );

  cv32e40s_txn_tracker #(.DEPTH(3), .TAG_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(d3_req_valid), .req_ready_o(d3_req_ready), .req_tag_i(d3_req_tag),
    .trans_valid_o(d3_trans_valid), .trans_ready_i(d3_trans_ready),
    .resp_valid_i(d3_resp_valid), .resp_valid_o(d3_resp_valid_o), .resp_tag_o(d3_resp_tag),
    .cnt_o(d3_cnt), .empty_o(d3_empty), .one_txn_pend_n_o(d3_one_pend), .unexp_resp_o(d3_unexp)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 0; req_tag = 0; trans_ready = 0; resp_valid = 0;
    d3_req_valid = 0; d3_req_tag = 0; d3_trans_ready = 1; d3_resp_valid = 0;
    #3;
    chk("rst_cnt", cnt, 0);
    chk("rst_empty", empty, 1);
    chk("rst_unexp", unexp, 0);
    chk("rst_tag", resp_tag, 0);
    chk("rst_resp_vld", resp_valid_o, 0);
    chk("rdy_follow_0", req_ready, 0);
    trans_ready = 1; #1;
    chk("rdy_follow_1", req_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    cyc();

    // Single transaction, tag 2'b10
    req_valid = 1; req_tag = 2'b10; #1;
    chk("acc_trans_vld", trans_valid, 1);
    chk("acc_req_rdy", req_ready, 1);
    chk("acc_one_pend", one_pend, 1);
    cyc();
    req_valid = 0;
    chk("one_cnt", cnt, 1);
    chk("one_empty", empty, 0);
    resp_valid = 1; #1;
    chk("one_resp_vld", resp_valid_o, 1);
    chk("one_resp_tag", resp_tag, 2'b10);
    chk("one_pend_ret", one_pend, 0);
    cyc();
    resp_valid = 0; #1;
    chk("one_cnt_after", cnt, 0);
    chk("one_tag_empty", resp_tag, 0);

    // Fill to DEPTH=2 with tags 1,2
    req_valid = 1; req_tag = 2'd1;
    cyc();
    req_tag = 2'd2; #1;
    chk("fill_pend", one_pend, 0);
    cyc();
    req_tag = 2'd3; #1;
    chk("full_cnt", cnt, 2);
    chk("full_rdy", req_ready, 0);
    chk("full_tvld", trans_valid, 0);
    chk("full_head", resp_tag, 1);

    // Response and new request together at full
    resp_valid = 1; #1;
    chk("fr_resp_vld", resp_valid_o, 1);
    chk("fr_resp_tag", resp_tag, 1);
`ifdef CV32E40S_TXN_TRACKER_FULL_BYPASS_EN
    chk("fr_rdy", req_ready, 1);
    chk("fr_tvld", trans_valid, 1);
    chk("fr_pend", one_pend, 0);
    cyc();
    req_valid = 0; #1;
    chk("fr_cnt", cnt, 2);
    chk("c2_ret_tag", resp_tag, 2);
    chk("c2_ret_pend", one_pend, 1);
    cyc();
    chk("c1_cnt", cnt, 1);
    chk("c1_tag", resp_tag, 3);
    cyc();
    resp_valid = 0; #1;
    chk("drain_cnt", cnt, 0);
`else
    chk("fr_rdy", req_ready, 0);
    chk("fr_tvld", trans_valid, 0);
    chk("fr_pend", one_pend, 1);
    cyc();
    chk("fr_cnt", cnt, 1);
    chk("nx_rdy", req_ready, 1);
    chk("c1_ar_tag", resp_tag, 2);
    chk("c1_ar_pend", one_pend, 1);
    cyc();
    req_valid = 0; #1;
    chk("c1_ar_cnt", cnt, 1);
    chk("c1_tag", resp_tag, 3);
    cyc();
    resp_valid = 0; #1;
    chk("drain_cnt", cnt, 0);
`endif

    // Response with nothing outstanding
    resp_valid = 1; #1;
    chk("ux_resp_vld", resp_valid_o, 0);
    chk("ux_not_yet", unexp, 0);
    cyc();
    resp_valid = 0; #1;
    chk("ux_set", unexp, 1);
    chk("ux_cnt", cnt, 0);
    cyc();
    chk("ux_sticky", unexp, 1);

    // DEPTH=3 pointer wrap, 10 accept/retire pairs
    for (int i = 0; i < 10; i++) begin
      d3_req_valid = 1; d3_req_tag = 2'((i * 3 + 1) % 4);
      cyc();
      d3_req_valid = 0; d3_resp_valid = 1; #1;
      chk($sformatf("wrap_vld%0d", i), d3_resp_valid_o, 1);
      chk($sformatf("wrap_tag%0d", i), d3_resp_tag, 8'((i * 3 + 1) % 4));
      cyc();
      d3_resp_valid = 0;
      chk($sformatf("wrap_cnt%0d", i), d3_cnt, 0);
    end
    // Three deep on DEPTH=3, then drain in order
    for (int i = 0; i < 3; i++) begin
      d3_req_valid = 1; d3_req_tag = 2'(3 - i);
      cyc();
    end
    d3_req_valid = 0; #1;
    chk("d3_full_cnt", d3_cnt, 3);
    chk("d3_full_rdy", d3_req_ready, 0);
    d3_resp_valid = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("d3_drain_tag%0d", i), d3_resp_tag, 8'(3 - i));
      cyc();
    end
    d3_resp_valid = 0; #1;
    chk("d3_drained", d3_cnt, 0);

    // Mid-stream asynchronous reset with two outstanding
    req_valid = 1; req_tag = 2'd1;
    cyc();
    req_tag = 2'd2;
    cyc();
    req_valid = 0; #1;
    chk("pre_rst_cnt", cnt, 2);
    #1 rst_n = 1'b0; #1;
    chk("arst_cnt", cnt, 0);
    chk("arst_empty", empty, 1);
    chk("arst_unexp", unexp, 0);
    chk("arst_tag", resp_tag, 0);
    @(negedge clk); rst_n = 1'b1;
    cyc();
    chk("post_rst_cnt", cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
